bcd_to_bin_seq: RTL and testbench
=================================

// Module: bcd_to_bin_seq
// PURPOSE
//  Sequential BCD-to-binary converter (reverse double-dabble: shift right, then subtract 3 from each digit >= 8).
//  It is the inverse of the display-path binary-to-BCD conversion.
//  Converts operator/UART-entered decimal values, such as HR/SpO2 alarm thresholds, into binary for compare logic.
//  Start/done handshake; one iteration per clock; checks that every input digit is valid.
// PARAMETERS
//  DIGITS  3   number of BCD digits in bcd_in; digit 0 = least significant, at bcd_in[3:0]
//  BIN_W   10  binary result width; must be >= ceil(log2(10^DIGITS)); elaboration fails otherwise
// PORTS
//  clk      in   1          single clock; all state updates on rising edge
//  rst      in   1          synchronous reset, active-high
//  start    in   1          request a conversion; sampled only in IDLE
//  bcd_in   in   4*DIGITS   packed BCD operand; sampled on the edge that accepts start
//  busy     out  1          high while a conversion is in progress
//  done     out  1          one-cycle pulse: bin_out/err updated this cycle
//  bin_out  out  BIN_W      converted value; held until the next done
//  err      out  1          1 = last request had a digit > 9; held until the next done
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - state=IDLE; busy=0, done=0, bin_out=0, err=0; iteration counter=0
//   - overrides every other input; a conversion in progress is aborted and produces no done
//  Working register: {digits[4*DIGITS-1:0], acc[BIN_W-1:0]}; counter width = clog2(BIN_W+1).
//  States: IDLE, CONV.
//  IDLE, start=1 and every digit <= 9:
//   - load digits=bcd_in, acc=0, cnt=0; busy<=1; state<=CONV
//  IDLE, start=1 and any digit > 9:
//   - stay in IDLE; done<=1, err<=1, bin_out<=0; busy stays 0
//  CONV, each edge, one iteration:
//   - shift {digits,acc} right 1 bit; digits MSB <= 0
//   - then, per digit independently: if shifted digit >= 8, subtract 3 (4-bit, no borrow across digits)
//   - cnt<=cnt+1
//  CONV, edge performing iteration BIN_W:
//   - bin_out <= post-shift acc; err<=0; done<=1; busy<=0; state<=IDLE
//  done is a registered single-cycle pulse: deasserted on every edge that does not set it.
//  Latency, valid request:
//   - start high in cycle 0 -> busy high cycles 1..BIN_W; done high in cycle BIN_W+1 (11 by default)
//  Latency, invalid request: done and err high in cycle 1.
//  Handshake:
//   - start while busy is ignored; it is not queued
//   - start asserted in the done cycle is accepted, since the state is IDLE then
//   - a start held high re-triggers a conversion on every return to IDLE
//   - bcd_in may change freely after the accepting edge
//  Arithmetic:
//   - no overflow is possible, given the BIN_W legality check
//   - all-digits-9 yields 10^DIGITS-1
//   - upper acc bits beyond the result are zero
// TESTING
//  1. rst, then start with bcd_in=12'h000 -> done in cycle 11, bin_out=0, err=0.
//  2. bcd_in=12'h255 -> bin_out=10'd255 (0x0FF), err=0, busy high exactly 10 cycles.
//  3. bcd_in=12'h999 -> bin_out=10'd999 (0x3E7); also sweep all 1000 valid codes against a model.
//  4. bcd_in=12'h1A5 (middle digit invalid) -> done and err in cycle 1, bin_out=0, busy never high;
//     follow with 12'h042 -> bin_out=42, err=0.
//  5. Back-to-back: start held high with 12'h100, then 12'h007 -> done pulses 11 cycles apart,
//     bin_out 100 then 7; extra starts during busy ignored.
//  6. rst asserted in cycle 5 of a conversion -> no done; all outputs 0 next cycle;
//     a new start then converts correctly.

Source files
------------

// File: rtl/bcd_to_bin_seq_if.sv
// Start/done handshake bundle for the sequential BCD-to-binary converter.
// The master issues requests, and the converter sits on the slave side.
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, err
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, err
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// Each iteration shifts right, then takes 3 from every BCD digit that is 8 or more.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic            clk,
    input  logic            rst,
    bcd_to_bin_seq_if.slave bus
);
    localparam int NEED_W = $clog2(10 ** DIGITS);
    localparam int CW     = $clog2(BIN_W + 1);
    localparam int WW     = 4 * DIGITS + BIN_W;
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    generate
        if (BIN_W < NEED_W) begin : g_bad_width
            $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
        end
    endgenerate

    typedef enum logic {IDLE, CONV} state_t;

    state_t              state, state_nxt;
    logic [4*DIGITS-1:0] digits, digits_nxt;
    logic [BIN_W-1:0]    acc, acc_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic                busy_r, busy_nxt;
    logic                done_r, done_nxt;
    logic [BIN_W-1:0]    bin_r, bin_nxt;
    logic                err_r, err_nxt;
    logic [WW-1:0]       shifted;
    logic [4*DIGITS-1:0] corr;

    function automatic logic [3:0] fix_digit(input logic [3:0] d);
        return (d >= 4'd8) ? (d - 4'd3) : d;
    endfunction

    function automatic logic all_valid(input logic [4*DIGITS-1:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    always_comb begin
        shifted = {digits, acc} >> 1;
        corr    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            corr[4*i +: 4] = fix_digit(shifted[BIN_W + 4*i +: 4]);
        end
    end

    always_comb begin
        state_nxt  = state;
        digits_nxt = digits;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        busy_nxt   = busy_r;
        done_nxt   = 1'b0;
        bin_nxt    = bin_r;
        err_nxt    = err_r;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (all_valid(bus.bcd_in)) begin
                        digits_nxt = bus.bcd_in;
                        acc_nxt    = '0;
                        cnt_nxt    = '0;
                        busy_nxt   = 1'b1;
                        state_nxt  = CONV;
                    end else begin
                        // Bad digit: report immediately without entering CONV.
                        done_nxt = 1'b1;
                        err_nxt  = 1'b1;
                        bin_nxt  = '0;
                    end
                end
            end
            CONV: begin
                digits_nxt = corr;
                acc_nxt    = shifted[BIN_W-1:0];
                cnt_nxt    = cnt + 1'b1;
                if (cnt == LAST) begin
                    bin_nxt   = shifted[BIN_W-1:0];
                    err_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            bin_r  <= '0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
            bin_r  <= bin_nxt;
            err_r  <= err_nxt;
        end
    end

    // The working register is always reloaded before use, so it is left out of reset.
    always_ff @(posedge clk) begin
        digits <= digits_nxt;
        acc    <= acc_nxt;
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.bin_out = bin_r;
    assign bus.err     = err_r;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized and directed bench for bcd_to_bin_seq.
// Expected values come from a decimal-arithmetic reference model.
module tb_bcd_to_bin_seq;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int BCD_W  = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();
    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: bit BIN_W is the error flag, and the low bits are the decimal value.
    function automatic logic [BIN_W:0] model(input logic [BCD_W-1:0] bcd);
        int v;
        int d;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(bcd[4*i +: 4]);
            if (d > 9) return {1'b1, {BIN_W{1'b0}}};
            v = v * 10 + d;
        end
        return {1'b0, BIN_W'(v)};
    endfunction

    task automatic do_conv(input logic [BCD_W-1:0] bcd, output int cyc, output int bcnt);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        cyc  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.start  = 1'b0;
                bus.bcd_in = BCD_W'($urandom);
            end
            if (bus.busy) bcnt++;
        end while (!bus.done && cyc < 40);
    endtask

    task automatic run_check(input string tag, input logic [BCD_W-1:0] bcd);
        int cyc, bcnt;
        logic [BIN_W:0] exp;
        exp = model(bcd);
        do_conv(bcd, cyc, bcnt);
        check({tag, " latency"}, 32'(cyc), exp[BIN_W] ? 32'd1 : 32'(BIN_W + 1));
        check({tag, " bin"}, 32'(bus.bin_out), 32'(exp[BIN_W-1:0]));
        check({tag, " err"}, 32'(bus.err), 32'(exp[BIN_W]));
        check({tag, " busy cycles"}, 32'(bcnt), exp[BIN_W] ? 32'd0 : 32'(BIN_W));
        @(negedge clk);
        check({tag, " done pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int cyc, pulses, first, second;
        logic [BIN_W-1:0] b1, b2;
        logic [BCD_W-1:0] r;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset bin", 32'(bus.bin_out), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        rst = 1'b0;

        run_check("h000", 12'h000);
        run_check("h255", 12'h255);
        run_check("h999", 12'h999);
        run_check("h1A5", 12'h1A5);
        run_check("h042", 12'h042);
        run_check("hF00", 12'hF00);
        run_check("h00A", 12'h00A);

        // Hold start high through two conversions; the operand changes while busy.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h100;
        cyc = 0; pulses = 0; first = 0; second = 0; b1 = '0; b2 = '0;
        while (cyc < 60 && second == 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) bus.bcd_in = 12'h007;
            if (pulses == 1 && cyc == first + 1) bus.start = 1'b0;
            if (bus.done) begin
                pulses++;
                if (pulses == 1) begin first = cyc; b1 = bus.bin_out; end
                else begin second = cyc; b2 = bus.bin_out; end
            end
        end
        check("b2b first done cycle", 32'(first), 32'(BIN_W + 1));
        check("b2b second done cycle", 32'(second), 32'(2 * (BIN_W + 1)));
        check("b2b first bin", 32'(b1), 32'd100);
        check("b2b second bin", 32'(b2), 32'd7);
        repeat (3) @(negedge clk);
        check("b2b no third conversion", 32'(bus.busy), 32'd0);

        // Reset in the middle of a conversion aborts it without a done pulse.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h321;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 5) rst = 1'b1;
        end
        @(negedge clk);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort bin", 32'(bus.bin_out), 32'd0);
        check("abort err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("abort no done", 32'(pulses), 32'd0);
        run_check("after abort h042", 12'h042);

        // Full sweep of the valid codes.
        for (int v = 0; v < 1000; v++) begin
            r = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            run_check($sformatf("sweep %0d", v), r);
        end

        // Random codes, including invalid digits.
        repeat (200) begin
            r = BCD_W'($urandom);
            run_check($sformatf("rand h%03h", r), r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
